// File: rtl/riscv_lsu_pkg.sv
// riscv_lsu_pkg
//   Shared types and helpers for the RV32I load/store unit.
//   - lsu_state_e : access sequencer states (IDLE, REQ, WAIT, DONE)
//   - F3_*        : RV32I funct3 codes for loads/stores
//   - f3_legal    : funct3 legality for a load or a store
//   - lane_off    : byte lane of the addressed item (natural alignment forced)
//   - store_be    : byte enables for a store of a given size
//   - misaligned  : true when the address is not naturally aligned for the size
package riscv_lsu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } lsu_state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Stores only have the signed-looking encodings; BU/HU are load-only.
  function automatic logic f3_legal(input logic we, input logic [2:0] f3);
    if (we)
      return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
           (f3 == F3_BU) || (f3 == F3_HU);
  endfunction

  // sz is funct3[1:0]: 00 byte, 01 half, 10 word.
  function automatic logic [1:0] lane_off(input logic [1:0] sz, input logic [1:0] a);
    case (sz)
      2'b00:   return a;
      2'b01:   return {a[1], 1'b0};
      default: return 2'b00;
    endcase
  endfunction

  function automatic logic [3:0] store_be(input logic [1:0] sz, input logic [1:0] a);
    case (sz)
      2'b00:   return 4'b0001 << a;
      2'b01:   return 4'b0011 << {a[1], 1'b0};
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic misaligned(input logic [1:0] sz, input logic [1:0] a);
    case (sz)
      2'b01:   return a[0];
      2'b10:   return |a;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/riscv_lsu_align.sv
// riscv_lsu_align
//   Combinational byte-lane steering for the load/store unit.
//   Ports:
//     func3    in  3   RV32I funct3 of the access
//     addr_lo  in  2   low byte-address bits
//     st_data  in  DW  store data from the register file
//     ld_word  in  DW  word returned by the data bus
//     be       out 4   store byte enables
//     st_lanes out DW  store data replicated across lanes
//     ld_data  out DW  selected, sign/zero-extended load result
module riscv_lsu_align
  import riscv_lsu_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic [2:0]    func3,
  input  logic [1:0]    addr_lo,
  input  logic [DW-1:0] st_data,
  input  logic [DW-1:0] ld_word,
  output logic [3:0]    be,
  output logic [DW-1:0] st_lanes,
  output logic [DW-1:0] ld_data
);

  logic [1:0]           off;
  logic [7:0]           ld_byte;
  logic [15:0]          ld_half;
  logic signed [7:0]    byte_s;
  logic signed [15:0]   half_s;
  logic signed [DW-1:0] byte_sx;
  logic signed [DW-1:0] half_sx;

  always_comb begin
    off      = lane_off(func3[1:0], addr_lo);
    be       = store_be(func3[1:0], addr_lo);

    ld_byte  = ld_word[{off, 3'b000} +: 8];
    ld_half  = ld_word[{off[1], 4'b0000} +: 16];
    byte_s   = $signed(ld_byte);
    half_s   = $signed(ld_half);
    byte_sx  = DW'(byte_s);
    half_sx  = DW'(half_s);

    case (func3)
      F3_B:    ld_data = byte_sx;
      F3_BU:   ld_data = DW'(ld_byte);
      F3_H:    ld_data = half_sx;
      F3_HU:   ld_data = DW'(ld_half);
      default: ld_data = ld_word;
    endcase

    case (func3[1:0])
      2'b00:   st_lanes = {4{st_data[7:0]}};
      2'b01:   st_lanes = {2{st_data[15:0]}};
      default: st_lanes = st_data;
    endcase
  end

endmodule

// File: rtl/riscv_lsu.sv
// riscv_lsu
//   Load/store unit for the single-cycle core. Accepts one load/store from
//   the core, runs it over a req/gnt/rvalid data bus and returns the
//   extended load data (or store completion) with a one-cycle rsp_valid.
//   stall freezes the PC and writeback while the access is in flight.
//   Optional build macro LSU_MISALIGN_TRAP_EN: misaligned H/W accesses
//   complete with an error and no bus cycle, and the misalign output exists.
//   Without it, low address bits are ignored to force natural alignment.
//   Ports:
//     cpu_clk, reset (async, active-low)
//     req_valid/req_we/req_func3/req_addr/req_wdata  core request
//     stall                                          hold core (combinational)
//     rsp_valid/rsp_rdata/rsp_err                    completion pulse
//     bus_req/bus_we/bus_addr/bus_be/bus_wdata       bus request side
//     bus_gnt/bus_rvalid/bus_rdata/bus_err           bus response side
//     misalign (macro only)                          misalign trap flag
module riscv_lsu
  import riscv_lsu_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          cpu_clk,
  input  logic          reset,
  input  logic          req_valid,
  input  logic          req_we,
  input  logic [2:0]    req_func3,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_wdata,
  output logic          stall,
  output logic          rsp_valid,
  output logic [DW-1:0] rsp_rdata,
  output logic          rsp_err,
  output logic          bus_req,
  output logic          bus_we,
  output logic [AW-1:0] bus_addr,
  output logic [3:0]    bus_be,
  output logic [DW-1:0] bus_wdata,
  input  logic          bus_gnt,
  input  logic          bus_rvalid,
  input  logic [DW-1:0] bus_rdata,
  input  logic          bus_err
`ifdef LSU_MISALIGN_TRAP_EN
  ,
  output logic          misalign
`endif
);

  lsu_state_e    state_q, state_d;
  logic          we_q;
  logic [2:0]    f3_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic [DW-1:0] rdata_q;
  logic          err_q;
  logic          accept;
  logic          cap_rsp;
  logic          bad_req;
  logic          mis_req;
  logic [3:0]    al_be;
  logic [DW-1:0] al_wdata;
  logic [DW-1:0] al_rdata;
`ifdef LSU_MISALIGN_TRAP_EN
  logic          mis_q;
`endif

  riscv_lsu_align #(.DW(DW)) u_align (
    .func3    (f3_q),
    .addr_lo  (addr_q[1:0]),
    .st_data  (wdata_q),
    .ld_word  (bus_rdata),
    .be       (al_be),
    .st_lanes (al_wdata),
    .ld_data  (al_rdata)
  );

  // Requests that can never reach the bus go straight to DONE with an error.
  always_comb begin
    bad_req = !f3_legal(req_we, req_func3);
    mis_req = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
    mis_req = !bad_req && misaligned(req_func3[1:0], req_addr[1:0]);
`endif
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    cap_rsp = 1'b0;
    case (state_q)
      IDLE: if (req_valid) begin
        accept  = 1'b1;
        state_d = (bad_req || mis_req) ? DONE : REQ;
      end
      REQ:  if (bus_gnt) state_d = WAIT;
      WAIT: if (bus_rvalid) begin
        cap_rsp = 1'b1;
        state_d = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs decode from the state so they are all 0 while in reset; stall is
  // additionally gated by reset because req_valid may still be high then.
  always_comb begin
    stall     = reset && (((state_q == IDLE) && req_valid) ||
                          (state_q == REQ) || (state_q == WAIT));
    rsp_valid = (state_q == DONE);
    rsp_err   = (state_q == DONE) && err_q;
    rsp_rdata = (state_q == DONE) ? rdata_q : '0;
    bus_req   = (state_q == REQ);
    bus_we    = (state_q == REQ) && we_q;
    bus_addr  = (state_q == REQ) ? {addr_q[AW-1:2], 2'b00} : '0;
    bus_be    = (state_q == REQ) ? al_be : 4'b0000;
    bus_wdata = (state_q == REQ) ? al_wdata : '0;
`ifdef LSU_MISALIGN_TRAP_EN
    misalign  = (state_q == DONE) && mis_q;
`endif
  end

  always_ff @(posedge cpu_clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      err_q   <= 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
      mis_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      if (accept) begin
        err_q <= bad_req || mis_req;
`ifdef LSU_MISALIGN_TRAP_EN
        mis_q <= mis_req;
`endif
      end else if (cap_rsp) begin
        err_q <= bus_err;
      end
    end
  end

  // Request fields and the result word are only observed in states entered
  // after an accept, so they carry no reset.
  always_ff @(posedge cpu_clk) begin
    if (accept) begin
      we_q    <= req_we;
      f3_q    <= req_func3;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
      rdata_q <= '0;
    end else if (cap_rsp) begin
      rdata_q <= (bus_err || we_q) ? '0 : al_rdata;
    end
  end

endmodule

// File: tb/tb_riscv_lsu.sv
module tb_riscv_lsu;

`ifdef LSU_MISALIGN_TRAP_EN
  localparam bit MIS = 1'b1;
`else
  localparam bit MIS = 1'b0;
`endif

  logic        cpu_clk = 1'b0;
  logic        reset;
  logic        req_valid, req_we;
  logic [2:0]  req_func3;
  logic [31:0] req_addr, req_wdata;
  logic        stall, rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic        bus_req, bus_we;
  logic [31:0] bus_addr, bus_wdata;
  logic [3:0]  bus_be;
  logic        bus_gnt, bus_rvalid, bus_err;
  logic [31:0] bus_rdata;
`ifdef LSU_MISALIGN_TRAP_EN
  logic        misalign;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 cpu_clk = ~cpu_clk;

  riscv_lsu #(.AW(32), .DW(32)) dut (
    .cpu_clk    (cpu_clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_we     (req_we),
    .req_func3  (req_func3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .stall      (stall),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .bus_req    (bus_req),
    .bus_we     (bus_we),
    .bus_addr   (bus_addr),
    .bus_be     (bus_be),
    .bus_wdata  (bus_wdata),
    .bus_gnt    (bus_gnt),
    .bus_rvalid (bus_rvalid),
    .bus_rdata  (bus_rdata),
    .bus_err    (bus_err)
`ifdef LSU_MISALIGN_TRAP_EN
    ,
    .misalign   (misalign)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // ---------------- reference model (byte-level arithmetic) ----------------
  function automatic bit ref_legal(input bit we, input int f3);
    if (we) return (f3 >= 0) && (f3 <= 2);
    return (f3 == 0) || (f3 == 1) || (f3 == 2) || (f3 == 4) || (f3 == 5);
  endfunction

  function automatic int ref_size(input int f3);
    if (f3 % 4 == 0) return 1;
    if (f3 % 4 == 1) return 2;
    return 4;
  endfunction

  function automatic bit ref_misal(input int f3, input logic [31:0] a);
    return (a % ref_size(f3)) != 0;
  endfunction

  // offset of the naturally aligned item containing the address
  function automatic int ref_off(input int f3, input logic [31:0] a);
    int n;
    n = ref_size(f3);
    return ((a % 4) / n) * n;
  endfunction

  function automatic logic [3:0] ref_be(input int f3, input logic [31:0] a);
    int n;
    n = ref_size(f3);
    return 4'(((1 << n) - 1) << ref_off(f3, a));
  endfunction

  function automatic logic [31:0] ref_wdata(input int f3, input logic [31:0] wd);
    int n;
    n = ref_size(f3);
    if (n == 1) return (wd & 32'hFF) * 32'h01010101;
    if (n == 2) return (wd & 32'hFFFF) * 32'h00010001;
    return wd;
  endfunction

  function automatic logic [31:0] ref_load(input int f3, input logic [31:0] a,
                                           input logic [31:0] rd);
    int n;
    logic [31:0] v;
    n = ref_size(f3);
    if (n == 4) return rd;
    v = rd >> (8 * ref_off(f3, a));
    v = v % (32'd1 << (8 * n));
    if (f3 < 4 && v >= (32'd1 << (8 * n - 1)))
      v = v - (32'd1 << (8 * n));
    return v;
  endfunction

  // ---------------- one core access with a responding bus ----------------
  task automatic access(input string nm, input bit we, input int f3,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input int gdly, input int rdly,
                        input logic [31:0] rd, input bit berr);
    bit          nobus, exp_err, exp_mis, got;
    logic [31:0] exp_rd;
    int          exp_lat, ph, rq, wc;
    exp_mis = MIS && ref_legal(we, f3) && ref_misal(f3, addr);
    nobus   = !ref_legal(we, f3) || exp_mis;
    exp_err = nobus ? 1'b1 : berr;
    exp_rd  = (exp_err || we) ? 32'h0 : ref_load(f3, addr, rd);
    exp_lat = nobus ? 1 : gdly + rdly + 2;

    @(negedge cpu_clk);
    req_valid = 1'b1; req_we = we; req_func3 = 3'(f3);
    req_addr = addr; req_wdata = wd;
    #1;
    chk({nm, "/stall_accept"}, stall, 1);
    chk({nm, "/req_idle"}, bus_req, 0);

    ph = 0; rq = 0; wc = 0; got = 1'b0;
    for (int i = 1; i <= 64; i++) begin
      @(posedge cpu_clk); #1;
      bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_err = 1'b0; bus_rdata = $urandom;
      if (rsp_valid) begin
        got = 1'b1;
        chk({nm, "/latency"}, i, exp_lat);
        chk({nm, "/stall_done"}, stall, 0);
        chk({nm, "/rsp_err"}, rsp_err, exp_err);
        chk({nm, "/rsp_rdata"}, rsp_rdata, exp_rd);
`ifdef LSU_MISALIGN_TRAP_EN
        chk({nm, "/misalign"}, misalign, exp_mis);
`endif
        break;
      end
      chk({nm, "/stall"}, stall, 1);
      if (ph == 0) begin
        chk({nm, "/bus_req"}, bus_req, !nobus);
        if (rq == 0 && !nobus) begin
          chk({nm, "/bus_addr"}, bus_addr, {addr[31:2], 2'b00});
          chk({nm, "/bus_be"}, bus_be, ref_be(f3, addr));
          chk({nm, "/bus_we"}, bus_we, we);
          if (we) chk({nm, "/bus_wdata"}, bus_wdata, ref_wdata(f3, wd));
        end
        rq++;
        if (rq - 1 == gdly) begin
          bus_gnt = 1'b1;
          ph = 1;
        end else begin
          bus_rvalid = ($urandom % 4 == 0);  // stray, must be ignored in REQ
        end
      end else begin
        chk({nm, "/req_drop"}, bus_req, 0);
        wc++;
        if (wc == rdly) begin
          bus_rvalid = 1'b1; bus_rdata = rd; bus_err = berr;
        end
      end
    end
    if (!got) chk({nm, "/timeout"}, 0, 1);
    req_valid = 1'b0;
    @(posedge cpu_clk); #1;
    bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_err = 1'b0;
    chk({nm, "/rsp_pulse"}, rsp_valid, 0);
    chk({nm, "/stall_after"}, stall, 0);
  endtask

  int lt[5] = '{0, 1, 2, 4, 5};

  initial begin
    reset = 1'b0;
    req_valid = 1'b1; req_we = 1'b0; req_func3 = 3'b010;
    req_addr = 32'h0; req_wdata = 32'h0;
    bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_err = 1'b0; bus_rdata = 32'h0;
    repeat (2) @(posedge cpu_clk);
    @(negedge cpu_clk);
    chk("rst/stall", stall, 0);
    chk("rst/rsp_valid", rsp_valid, 0);
    chk("rst/rsp_rdata", rsp_rdata, 0);
    chk("rst/bus_req", bus_req, 0);
    chk("rst/bus_be", bus_be, 0);
    chk("rst/bus_addr", bus_addr, 0);
    req_valid = 1'b0;
    reset = 1'b1;

    access("sw",   1, 2, 32'h100, 32'hDEADBEEF, 0, 1, 32'h0, 0);
    access("lb",   0, 0, 32'h103, 32'h0, 0, 1, 32'h80123456, 0);
    access("lbu",  0, 4, 32'h103, 32'h0, 1, 2, 32'h80123456, 0);
    access("sh",   1, 1, 32'h202, 32'h1234ABCD, 0, 1, 32'h0, 0);
    access("lhu",  0, 5, 32'h202, 32'h0, 0, 1, 32'hABCD0000, 0);
    access("lh",   0, 1, 32'h200, 32'h0, 2, 1, 32'h1234F00D, 0);
    access("sb",   1, 0, 32'h301, 32'h000000A5, 0, 3, 32'h0, 0);
    access("berr", 0, 2, 32'h040, 32'h0, 4, 1, 32'hFFFFFFFF, 1);
    access("ill_ld", 0, 3, 32'h010, 32'h0, 0, 1, 32'h0, 0);
    access("ill_st", 1, 4, 32'h010, 32'h55, 0, 1, 32'h0, 0);
    access("lw_mis", 0, 2, 32'h102, 32'h0, 0, 1, 32'hCAFEF00D, 0);

    // reset in the middle of an access
    @(negedge cpu_clk);
    req_valid = 1'b1; req_we = 1'b0; req_func3 = 3'b010; req_addr = 32'h300;
    @(posedge cpu_clk); #1;
    bus_gnt = 1'b1;
    @(posedge cpu_clk); #1;
    bus_gnt = 1'b0;
    chk("rstmid/in_wait", stall, 1);
    reset = 1'b0;
    #1;
    chk("rstmid/bus_req", bus_req, 0);
    chk("rstmid/stall", stall, 0);
    chk("rstmid/rsp_valid", rsp_valid, 0);
    @(negedge cpu_clk);
    req_valid = 1'b0; bus_rvalid = 1'b1; bus_rdata = 32'h12345678;
    @(negedge cpu_clk);
    reset = 1'b1;
    @(posedge cpu_clk); #1;
    bus_rvalid = 1'b0;
    chk("rstmid/late_rvalid", rsp_valid, 0);
    @(posedge cpu_clk); #1;
    chk("rstmid/idle", rsp_valid | stall | bus_req, 0);
    access("lw_after_rst", 0, 2, 32'h300, 32'h0, 0, 1, 32'h0BADC0DE, 0);

    // randomized traffic
    for (int k = 0; k < 150; k++) begin
      bit we;
      int f3;
      we = $urandom % 2;
      if ($urandom % 10 == 0) f3 = $urandom % 8;
      else f3 = we ? ($urandom % 3) : lt[$urandom % 5];
      access("rnd", we, f3, $urandom, $urandom, $urandom % 6, 1 + $urandom % 4,
             $urandom, ($urandom % 8) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
